// File: rtl/odu_chk_data.sv
// ODU data checker: per-channel sequence/payload verification with a 2-stage
// pipeline and a small async-style config register bank.
module odu_chk_data #(
  parameter int unsigned NUM_CH     = 80,
  parameter int unsigned DATA_WIDTH = 387
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_n_cs,
  input  logic                  cfg_n_we,
  input  logic                  cfg_n_oe,
  input  logic [3:0]            cfg_addr,
  input  logic [15:0]           cfg_din,
  output logic [15:0]           cfg_dout,
  input  logic [6:0]            chid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in
);

  localparam int unsigned CW       = 7;
  localparam int unsigned SW       = 16;
  localparam int unsigned PW       = 364;
  localparam int unsigned SEQ_LSB  = 364;
  localparam int unsigned ECHO_LSB = 380;

  localparam logic [3:0] ADDR_CTRL    = 4'h0;
  localparam logic [3:0] ADDR_WORD    = 4'h1;
  localparam logic [3:0] ADDR_ERR     = 4'h2;
  localparam logic [3:0] ADDR_CH_SEL  = 4'h3;
  localparam logic [3:0] ADDR_CH_STAT = 4'h4;
  localparam logic [3:0] ADDR_CH_EXP  = 4'h5;
  localparam logic [3:0] ADDR_BAD     = 4'h6;

  typedef enum logic {CH_IDLE = 1'b0, CH_LOCKED = 1'b1} ch_state_e;

  ch_state_e         st_q [NUM_CH];
  ch_state_e         st_d [NUM_CH];
  logic [SW-1:0]     exp_q [NUM_CH];
  logic [SW-1:0]     exp_d [NUM_CH];
  logic [NUM_CH-1:0] sticky_q, sticky_d;

  logic          enable;
  logic [CW-1:0] ch_sel;
  logic [SW-1:0] word_cnt, err_cnt, bad_cnt;
  logic [SW-1:0] word_d, err_d, bad_d;

  logic                  s1_valid;
  logic [CW-1:0]         s1_chid;
  logic [DATA_WIDTH-1:0] s1_data;

  logic          cfg_wr_c, cfg_rd_c, clr_c;
  logic          chid_ok_c, sel_ok_c, word_err_c;
  logic [CW-1:0] ch_idx_c, sel_idx_c;
  logic [SW-1:0] s1_seq_c;
  logic [CW-1:0] s1_echo_c;
  logic [PW-1:0] pattern_c;
  logic [15:0]   rd_mux_c;
  logic          unused_cfg_bits;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign cfg_wr_c        = !cfg_n_cs && !cfg_n_we;
  assign cfg_rd_c        = !cfg_n_cs && !cfg_n_oe;
  assign clr_c           = cfg_wr_c && (cfg_addr == ADDR_CTRL) && cfg_din[1];
  assign unused_cfg_bits = ^cfg_din[15:7];

  // Stage-2 decode of the registered word
  assign s1_seq_c   = s1_data[SEQ_LSB +: SW];
  assign s1_echo_c  = s1_data[ECHO_LSB +: CW];
  assign pattern_c  = {s1_seq_c[11:0], {22{s1_seq_c}}};
  assign chid_ok_c  = 32'(s1_chid) < NUM_CH;
  assign ch_idx_c   = chid_ok_c ? s1_chid : '0;
  assign word_err_c = (s1_seq_c != exp_q[ch_idx_c]) || (s1_echo_c != s1_chid) ||
                      (s1_data[PW-1:0] != pattern_c);
  assign sel_ok_c   = 32'(ch_sel) < NUM_CH;
  assign sel_idx_c  = sel_ok_c ? ch_sel : '0;

  // Channel state register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= CH_IDLE;
        exp_q[i] <= '0;
      end
      sticky_q <= '0;
    end else begin
      st_q     <= st_d;
      exp_q    <= exp_d;
      sticky_q <= sticky_d;
    end
  end

  // Channel next-state and counter update; clear beats disable beats the word
  always_comb begin
    st_d     = st_q;
    exp_d    = exp_q;
    sticky_d = sticky_q;
    word_d   = word_cnt;
    err_d    = err_cnt;
    bad_d    = bad_cnt;
    if (clr_c) begin
      for (int i = 0; i < NUM_CH; i++) st_d[i] = CH_IDLE;
      sticky_d = '0;
      word_d   = '0;
      err_d    = '0;
      bad_d    = '0;
    end else if (!enable) begin
      for (int i = 0; i < NUM_CH; i++) st_d[i] = CH_IDLE;
    end else if (s1_valid) begin
      if (!chid_ok_c) begin
        bad_d = sat_inc(bad_cnt);
      end else begin
        word_d = sat_inc(word_cnt);
        if (st_q[ch_idx_c] == CH_LOCKED && word_err_c) begin
          err_d              = sat_inc(err_cnt);
          sticky_d[ch_idx_c] = 1'b1;
        end
        st_d[ch_idx_c]  = CH_LOCKED;
        exp_d[ch_idx_c] = s1_seq_c + 16'd1;
      end
    end
  end

  // Read mux shows post-update values so a read sees the same-cycle result
  always_comb begin
    rd_mux_c = '0;
    case (cfg_addr)
      ADDR_CTRL:    rd_mux_c = {15'd0, enable};
      ADDR_WORD:    rd_mux_c = word_d;
      ADDR_ERR:     rd_mux_c = err_d;
      ADDR_CH_SEL:  rd_mux_c = {9'd0, ch_sel};
      ADDR_CH_STAT: rd_mux_c = sel_ok_c ? {14'd0, sticky_d[sel_idx_c],
                                           st_d[sel_idx_c] == CH_LOCKED} : 16'd0;
      ADDR_CH_EXP:  rd_mux_c = sel_ok_c ? exp_d[sel_idx_c] : 16'd0;
      ADDR_BAD:     rd_mux_c = bad_d;
      default:      rd_mux_c = '0;
    endcase
  end

  // Config registers, counters and stage-1 capture
  always_ff @(posedge clk) begin
    if (rst) begin
      enable   <= 1'b0;
      ch_sel   <= '0;
      word_cnt <= '0;
      err_cnt  <= '0;
      bad_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_chid  <= '0;
      s1_data  <= '0;
      cfg_dout <= '0;
    end else begin
      if (cfg_wr_c && cfg_addr == ADDR_CTRL)   enable <= cfg_din[0];
      if (cfg_wr_c && cfg_addr == ADDR_CH_SEL) ch_sel <= cfg_din[6:0];
      word_cnt <= word_d;
      err_cnt  <= err_d;
      bad_cnt  <= bad_d;
      s1_valid <= data_valid_in && enable && !clr_c;
      if (data_valid_in) begin
        s1_chid <= chid_in;
        s1_data <= data_in;
      end
      cfg_dout <= cfg_rd_c ? rd_mux_c : 16'd0;
    end
  end

endmodule

// File: tb/tb_odu_chk_data.sv
// Scoreboard bench for odu_chk_data: reads push expectations, a monitor checks cfg_dout.
module tb_odu_chk_data;

  localparam int unsigned DW = 387;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_n_cs, cfg_n_we, cfg_n_oe;
  logic [3:0]    cfg_addr;
  logic [15:0]   cfg_din;
  logic [15:0]   cfg_dout;
  logic [6:0]    chid_in;
  logic [DW-1:0] data_in;
  logic          data_valid_in;

  always #5 clk = ~clk;

  odu_chk_data #(.NUM_CH(80), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .cfg_n_cs(cfg_n_cs), .cfg_n_we(cfg_n_we), .cfg_n_oe(cfg_n_oe),
    .cfg_addr(cfg_addr), .cfg_din(cfg_din), .cfg_dout(cfg_dout),
    .chid_in(chid_in), .data_in(data_in), .data_valid_in(data_valid_in)
  );

  typedef struct {
    string       name;
    logic [15:0] val;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  logic rd_seen  = 1'b0;

  // Monitor: a read sampled on a rising edge is presented on cfg_dout until the next one
  always @(posedge clk) rd_seen <= !cfg_n_cs && !cfg_n_oe;

  always @(negedge clk) begin
    if (rd_seen) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read got=%h", cfg_dout);
      end else begin
        e = q.pop_front();
        if (cfg_dout !== e.val) begin
          failures++;
          $display("FAIL %s got=%h exp=%h", e.name, cfg_dout, e.val);
        end
      end
    end
  end

  function automatic logic [DW-1:0] mk(input logic [6:0] echo, input logic [15:0] seq);
    return {echo, seq, seq[11:0], {22{seq}}};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [6:0] ch, input logic [DW-1:0] d);
    chid_in = ch; data_in = d; data_valid_in = 1'b1;
    @(negedge clk);
    data_valid_in = 1'b0;
  endtask

  task automatic send(input logic [6:0] ch, input logic [15:0] seq);
    drive(ch, mk(ch, seq));
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    cfg_n_cs = 1'b0; cfg_n_we = 1'b0; cfg_addr = a; cfg_din = d;
    @(negedge clk);
    cfg_n_cs = 1'b1; cfg_n_we = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] e, input string name);
    cfg_n_cs = 1'b0; cfg_n_oe = 1'b0; cfg_addr = a;
    q.push_back('{name, e});
    @(negedge clk);
    cfg_n_cs = 1'b1; cfg_n_oe = 1'b1;
  endtask

  task automatic rd_reset_vals(input string tag);
    rd(4'h0, 16'h0000, {tag, "_ctrl"});
    rd(4'h1, 16'h0000, {tag, "_word"});
    rd(4'h2, 16'h0000, {tag, "_err"});
    rd(4'h3, 16'h0000, {tag, "_chsel"});
    rd(4'h4, 16'h0000, {tag, "_stat"});
    rd(4'h5, 16'h0000, {tag, "_exp"});
    rd(4'h6, 16'h0000, {tag, "_bad"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d;
    rst = 1'b1; cfg_n_cs = 1'b1; cfg_n_we = 1'b1; cfg_n_oe = 1'b1;
    cfg_addr = '0; cfg_din = '0; chid_in = '0; data_in = '0; data_valid_in = 1'b0;
    idle(3);
    rst = 1'b0;
    rd_reset_vals("reset");
    rd(4'h7, 16'h0000, "unmapped_7");

    // Clean stream on ch 5
    wr(4'h0, 16'h0001);
    for (int s = 16'h10; s <= 16'h13; s++) send(7'd5, 16'(s));
    idle(3);
    wr(4'h3, 16'h0005);
    rd(4'h1, 16'd4,    "ch5_word");
    rd(4'h2, 16'd0,    "ch5_err");
    rd(4'h4, 16'h0001, "ch5_stat");
    rd(4'h5, 16'h0014, "ch5_exp");
    rd(4'h0, 16'h0001, "ctrl_en");

    // Sequence jump on ch 3, expected resyncs
    send(7'd3, 16'h0001); send(7'd3, 16'h0002); send(7'd3, 16'h0005); send(7'd3, 16'h0006);
    idle(3);
    wr(4'h3, 16'h0003);
    rd(4'h2, 16'd1,    "ch3_err");
    rd(4'h4, 16'h0003, "ch3_stat");
    rd(4'h5, 16'h0007, "ch3_exp");

    // Sequence wrap on ch 0
    send(7'd0, 16'hFFFE); send(7'd0, 16'hFFFF); send(7'd0, 16'h0000);
    idle(3);
    wr(4'h3, 16'h0000);
    rd(4'h2, 16'd1,    "wrap_err");
    rd(4'h4, 16'h0001, "wrap_stat");
    rd(4'h5, 16'h0001, "wrap_exp");
    rd(4'h1, 16'd11,   "wrap_word");

    // Out-of-range channel ids
    send(7'd80, 16'h0000); send(7'd127, 16'h0000);
    idle(3);
    rd(4'h6, 16'd2,  "badchid_cnt");
    rd(4'h1, 16'd11, "badchid_word");
    rd(4'h2, 16'd1,  "badchid_err");

    // Clear, then payload corruption on ch 7 and clear racing the next word
    wr(4'h0, 16'h0003);
    idle(2);
    rd(4'h2, 16'd0, "clr1_err");
    send(7'd7, 16'h0020);
    d = mk(7'd7, 16'h0021);
    d[0] = ~d[0];
    drive(7'd7, d);
    idle(3);
    wr(4'h3, 16'h0007);
    rd(4'h2, 16'd1,    "ch7_err_pre");
    rd(4'h4, 16'h0003, "ch7_stat_pre");
    cfg_n_cs = 1'b0; cfg_n_we = 1'b0; cfg_addr = 4'h0; cfg_din = 16'h0003;
    chid_in = 7'd7; data_in = mk(7'd7, 16'h0022); data_valid_in = 1'b1;
    @(negedge clk);
    cfg_n_cs = 1'b1; cfg_n_we = 1'b1; data_valid_in = 1'b0;
    idle(3);
    rd(4'h2, 16'd0,    "ch7_err_post");
    rd(4'h1, 16'd0,    "ch7_word_post");
    rd(4'h6, 16'd0,    "ch7_bad_post");
    rd(4'h4, 16'h0000, "ch7_stat_post");
    rd(4'h0, 16'h0001, "ch7_ctrl_post");

    // Word sitting in stage 2 on the clear cycle is dropped
    send(7'd11, 16'h0050);
    wr(4'h0, 16'h0003);
    idle(2);
    wr(4'h3, 16'd11);
    rd(4'h1, 16'd0,    "s2clr_word");
    rd(4'h4, 16'h0000, "s2clr_stat");

    // Echo mismatch on ch 9
    send(7'd9, 16'h0100);
    drive(7'd9, mk(7'd10, 16'h0101));
    idle(3);
    wr(4'h3, 16'd9);
    rd(4'h1, 16'd2,    "echo_word");
    rd(4'h2, 16'd1,    "echo_err");
    rd(4'h4, 16'h0003, "echo_stat");
    rd(4'h5, 16'h0102, "echo_exp");

    // Disabled: words ignored, channels idle, sticky and counters kept
    wr(4'h0, 16'h0000);
    send(7'd9, 16'h0102); send(7'd9, 16'h0200); send(7'd80, 16'h0000);
    idle(3);
    rd(4'h1, 16'd2,    "dis_word");
    rd(4'h2, 16'd1,    "dis_err");
    rd(4'h6, 16'd0,    "dis_bad");
    rd(4'h4, 16'h0002, "dis_stat");
    rd(4'h0, 16'h0000, "dis_ctrl");

    // Reset mid-stream while enabled
    wr(4'h0, 16'h0001);
    send(7'd2, 16'h0001);
    chid_in = 7'd2; data_in = mk(7'd2, 16'h0002); data_valid_in = 1'b1; rst = 1'b1;
    @(negedge clk);
    data_in = mk(7'd2, 16'h0009);
    @(negedge clk);
    data_valid_in = 1'b0; rst = 1'b0;
    idle(2);
    rd_reset_vals("rstmid");

    // Checking restarts from idle after re-enable
    wr(4'h0, 16'h0001);
    send(7'd5, 16'h0040);
    idle(3);
    wr(4'h3, 16'd5);
    rd(4'h1, 16'd1,    "resume_word");
    rd(4'h4, 16'h0001, "resume_stat");
    rd(4'h5, 16'h0041, "resume_exp");

    idle(3);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending_reads got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/odu_chk_data.md
ODU_CHK_DATA -- requirements
Module: odu_chk_data

Interface
REQ-001 Parameter NUM_CH, default 80, SHALL set the number of checked channels; valid chid range is 0..NUM_CH-1.
REQ-002 Parameter DATA_WIDTH, default 387, SHALL set the width of the received data word.
REQ-003 clk  input  1  SHALL be the single clock; all logic is rising-edge clocked.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 cfg_n_cs  input  1  SHALL be the active-low config chip select.
REQ-006 cfg_n_we  input  1  SHALL be the active-low config write enable.
REQ-007 cfg_n_oe  input  1  SHALL be the active-low config output enable.
REQ-008 cfg_addr  input  4  SHALL be the config register address.
REQ-009 cfg_din  input  16  SHALL be the config write data.
REQ-010 cfg_dout  output  16  SHALL be the registered config read data.
REQ-011 chid_in  input  7  SHALL be the channel id of the received word.
REQ-012 data_in  input  DATA_WIDTH  SHALL be the received ODU data word.
REQ-013 data_valid_in  input  1  SHALL qualify chid_in/data_in for one cycle per word.

Function
REQ-014 Word format: data_in[386:380]=chid echo; [379:364]=seq (16 b); [363:0]={seq[11:0], 22 copies of seq}.
REQ-015 Config write SHALL occur on a clk edge with cfg_n_cs=0 and cfg_n_we=0; read data SHALL appear on cfg_dout one cycle after cfg_n_cs=0 and cfg_n_oe=0, otherwise cfg_dout=0.
REQ-016 Register map: 0x0 CTRL (bit0 enable RW; bit1 clear, write-1 pulse, reads 0); 0x1 WORD_CNT; 0x2 ERR_CNT; 0x3 CH_SEL[6:0] RW; 0x4 CH_STAT (bit0 locked, bit1 sticky error); 0x5 CH_EXP (expected seq of CH_SEL); 0x6 BAD_CHID_CNT; other addresses SHALL read 0.
REQ-017 A word SHALL be accepted only when data_valid_in=1 and enable=1; it SHALL be registered in stage 1 and checked/state-updated in stage 2 (2-cycle latency to counter update).
REQ-018 Accepted word with chid_in >= NUM_CH SHALL increment BAD_CHID_CNT only; no channel state change; WORD_CNT unchanged.
REQ-019 Per-channel state SHALL be IDLE or LOCKED; IDLE -> LOCKED on first accepted word for that channel, loading expected = seq+1, no error counted.
REQ-020 In LOCKED, a word SHALL be in error if seq != expected, chid echo != chid_in, or payload != REQ-014 pattern; each erroneous word increments ERR_CNT by exactly 1 and sets that channel's sticky bit.
REQ-021 In LOCKED, expected SHALL become received seq+1 (mod 2^16) on every word, error or not (resynchronise); 0xFFFF wraps to 0x0000 without error.
REQ-022 WORD_CNT SHALL increment per accepted valid-chid word; WORD_CNT, ERR_CNT, BAD_CHID_CNT SHALL saturate at 0xFFFF.
REQ-023 Clear pulse SHALL zero all counters and sticky bits and set all channels IDLE; a word in stage 2 on the clear cycle SHALL be discarded (clear wins).
REQ-024 Deasserting enable SHALL set all channels IDLE and flush stage 1; counters and sticky bits SHALL be retained.
REQ-025 CH_STAT/CH_EXP SHALL reflect state after any update completing in the same cycle as the read sample.

Reset
REQ-026 On rst=1: enable=0, CH_SEL=0, all counters 0, all sticky bits 0, all channels IDLE, expected=0, pipeline empty, cfg_dout=0.
REQ-027 Reset mid-stream SHALL discard in-flight words; checking resumes from IDLE after enable is rewritten to 1.

Verification
REQ-028 Enable, send ch 5 seq 0x0010..0x0013 correct -> WORD_CNT=4, ERR_CNT=0, CH_SEL=5 gives CH_STAT=0x0001, CH_EXP=0x0014.
REQ-029 Ch 3 seq 0x0001, 0x0002, 0x0005, 0x0006 -> ERR_CNT=1, ch 3 sticky=1, CH_EXP=0x0007.
REQ-030 Ch 0 seq 0xFFFE, 0xFFFF, 0x0000 -> ERR_CNT=0, CH_EXP=0x0001.
REQ-031 chid_in=80 and 127, one word each -> BAD_CHID_CNT=2, WORD_CNT and ERR_CNT unchanged.
REQ-032 Corrupt payload bit 0 on ch 7 locked word, then write CTRL=0x0003 same cycle as next word -> ERR_CNT=1 before clear, all 0 after, ch 7 IDLE.
REQ-033 Valid words with enable=0, then rst=1 mid-stream -> no counter changes; all registers read reset values.
